dmem_initiator: RTL and testbench

- Initiator side of the data-memory request/stall interface; sits between the processor's execute/memory stage and the data memory.
- Accepts one load/store per transaction from the pipeline over a valid/ready handshake.
- Encodes funct3 into the memory's sign_mask code, pulses memread or memwrite for exactly one cycle, and tracks the memory's clk_stall rise/fall.
- Returns the load word or an error on a single-cycle response strobe. Misaligned, out-of-range and illegal-funct3 accesses are rejected without touching memory; a stall that never rises or never falls is flagged as a protocol error.

---
 rtl/dmem_initiator_pkg.sv | 42 ++++
 rtl/dmem_initiator_if.sv | 50 +++++
 rtl/dmem_req_check.sv | 68 ++++++
 rtl/dmem_initiator.sv | 155 +++++++++++++++
 tb/tb_dmem_initiator.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_initiator_pkg.sv
// -----------------------------------------------------------------------------
// dmem_initiator_pkg
//   Shared constants for the data-memory initiator: RV32I load/store funct3
//   codes, the memory's sign_mask codes, default address map, stall timeout
//   and the FSM state encoding.
// -----------------------------------------------------------------------------
package dmem_initiator_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // sign_mask: bit3 = sign-extend, bits[2:0] = thermometer byte-lane size
    localparam logic [3:0] MASK_BU = 4'b0001;
    localparam logic [3:0] MASK_HU = 4'b0011;
    localparam logic [3:0] MASK_W  = 4'b0111;
    localparam logic [3:0] MASK_B  = 4'b1001;
    localparam logic [3:0] MASK_H  = 4'b1011;

    // Default address map and stall watchdog
    localparam logic [31:0] DMEM_BASE_DEFAULT     = 32'h0000_1000;
    localparam int unsigned DMEM_WORDS_DEFAULT    = 1024;
    localparam logic [31:0] LED_ADDR_DEFAULT      = 32'h0000_2000;
    localparam int unsigned STALL_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/dmem_initiator_if.sv
// -----------------------------------------------------------------------------
// Interfaces around dmem_initiator.
//   dmem_req_if : pipeline <-> initiator. master = pipeline, slave = initiator.
//     valid/ready handshake carrying we, funct3, addr, wdata; single-cycle
//     response strobe resp_valid with resp_rdata and resp_err.
//   dmem_mem_if : initiator <-> data memory. master = initiator, slave = memory.
//     addr, write_data, memwrite, memread, sign_mask out; read_data and
//     clk_stall back.
// -----------------------------------------------------------------------------
interface dmem_req_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output valid, we, funct3, addr, wdata,
        input  ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  valid, we, funct3, addr, wdata,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface dmem_mem_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall
    );
endinterface

// File: rtl/dmem_req_check.sv
// -----------------------------------------------------------------------------
// dmem_req_check
//   Purely combinational request decoder. Maps funct3/we to the memory's
//   sign_mask code and flags requests that must never reach memory:
//   illegal funct3, misaligned half/word, address outside data memory
//   (a store to LED_ADDR is the one legal exception).
// Ports:
//   we        in   1 = store, 0 = load
//   funct3    in   RV32I load/store funct3
//   addr      in   effective byte address
//   sign_mask out  memory sign_mask code (0 when funct3 is illegal)
//   err       out  request is rejected
// -----------------------------------------------------------------------------
module dmem_req_check
    import dmem_initiator_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT,
    parameter logic [31:0] LED_ADDR   = LED_ADDR_DEFAULT
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [3:0]  sign_mask,
    output logic        err
);

    localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(DMEM_WORDS * 4);

    logic f3_bad;
    logic misaligned;
    logic in_range;
    logic led_store;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        sign_mask = 4'b0000;
        f3_bad    = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB:   sign_mask = MASK_BU;
                F3_SH:   sign_mask = MASK_HU;
                F3_SW:   sign_mask = MASK_W;
                default: f3_bad    = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:   sign_mask = MASK_B;
                F3_LH:   sign_mask = MASK_H;
                F3_LW:   sign_mask = MASK_W;
                F3_LBU:  sign_mask = MASK_BU;
                F3_LHU:  sign_mask = MASK_HU;
                default: f3_bad    = 1'b1;
            endcase
        end
    end

    // funct3[1:0] encodes size for every legal code: 00 byte, 01 half, 10 word.
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign in_range  = (addr >= DMEM_BASE) && (addr < DMEM_END);
    assign led_store = we && (addr == LED_ADDR);

    assign err = f3_bad || misaligned || !(in_range || led_store);

endmodule

// File: rtl/dmem_initiator.sv
// -----------------------------------------------------------------------------
// dmem_initiator
//   Initiator side of the data-memory request/stall protocol. Accepts one
//   load/store from the pipeline, pulses memread/memwrite for one cycle,
//   follows the memory's clk_stall rise and fall, then returns a one-cycle
//   response. Rejected requests answer one edge after acceptance without
//   touching memory; a stall that never rises, or never falls within
//   STALL_TIMEOUT cycles, is answered with an error.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   req    slave modport of dmem_req_if (pipeline handshake + response)
//   mem    master modport of dmem_mem_if (data memory strobes + stall)
// -----------------------------------------------------------------------------
module dmem_initiator
    import dmem_initiator_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE     = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_WORDS    = DMEM_WORDS_DEFAULT,
    parameter logic [31:0] LED_ADDR      = LED_ADDR_DEFAULT,
    parameter int unsigned STALL_TIMEOUT = STALL_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    dmem_req_if.slave  req,
    dmem_mem_if.master mem
);

    localparam int CNT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

    state_t state;
    state_t state_next;

    logic             ready;
    logic             xfer;
    logic [3:0]       chk_mask;
    logic             chk_err;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       mask_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;

    dmem_req_check #(
        .DMEM_BASE  (DMEM_BASE),
        .DMEM_WORDS (DMEM_WORDS),
        .LED_ADDR   (LED_ADDR)
    ) u_check (
        .we        (req.we),
        .funct3    (req.funct3),
        .addr      (req.addr),
        .sign_mask (chk_mask),
        .err       (chk_err)
    );

    // The memory has no reset: a stall still high after our reset (or after a
    // timeout) must block new requests until the memory settles.
    assign ready     = (state == ST_IDLE) && !mem.clk_stall && !reset;
    assign xfer      = req.valid && ready;
    assign req.ready = ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (xfer) state_next = chk_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   state_next = ST_WAIT_HI;
            ST_WAIT_HI: state_next = mem.clk_stall ? ST_WAIT_LO : ST_RESP;
            ST_WAIT_LO: if (!mem.clk_stall || (cnt_q == CNT_LAST)) state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Request latch, stall watchdog and load-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        we_q    <= req.we;
                        addr_q  <= req.addr;
                        wdata_q <= req.wdata;
                        mask_q  <= chk_mask;
                        err_q   <= chk_err;
                        rdata_q <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (mem.clk_stall) cnt_q <= '0;
                    else               err_q <= 1'b1;   // memory never acknowledged
                end
                ST_WAIT_LO: begin
                    if (!mem.clk_stall) begin
                        if (!we_q) rdata_q <= mem.read_data;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;                  // stall never released
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. Strobes exist only in ISSUE so the memory can never see a
    // second access while it re-samples in its own idle state.
    always_comb begin
        mem.memread     = 1'b0;
        mem.memwrite    = 1'b0;
        mem.addr        = '0;
        mem.write_data  = '0;
        mem.sign_mask   = '0;
        req.resp_valid  = 1'b0;
        req.resp_err    = 1'b0;
        req.resp_rdata  = '0;
        case (state)
            ST_ISSUE, ST_WAIT_HI, ST_WAIT_LO: begin
                mem.memread    = (state == ST_ISSUE) && !we_q;
                mem.memwrite   = (state == ST_ISSUE) &&  we_q;
                mem.addr       = addr_q;
                mem.write_data = wdata_q;
                mem.sign_mask  = mask_q;
            end
            ST_RESP: begin
                req.resp_valid = 1'b1;
                req.resp_err   = err_q;
                req.resp_rdata = (err_q || we_q) ? 32'h0 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// -----------------------------------------------------------------------------
// tb_dmem_initiator
//   Table of directed load/store vectors with hand-computed expectations,
//   plus hand-written sequences for stall timeout, missing acknowledge,
//   reset in the middle of a stall, and back-to-back throughput.
//   Inputs change 1 time unit after the rising edge; a negedge monitor
//   samples DUT outputs.
// -----------------------------------------------------------------------------
module tb_dmem_initiator;
    import dmem_initiator_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_req_if rif ();
    dmem_mem_if mif ();

    dmem_initiator dut (
        .clk   (clk),
        .reset (reset),
        .req   (rif),
        .mem   (mif)
    );

    // ---------------- stub data memory ----------------
    typedef enum logic [1:0] {STUB_NORMAL, STUB_HANG, STUB_NOACK} stub_mode_t;
    stub_mode_t  stub_mode    = STUB_NORMAL;
    logic        hang_release = 1'b0;
    logic [31:0] stub_rdata   = 32'h0;
    logic        stub_stall   = 1'b0;
    logic [1:0]  busy         = 2'd0;
    logic [7:0]  led          = 8'h00;

    assign mif.read_data = stub_rdata;
    assign mif.clk_stall = stub_stall;

    // Nominal memory: stall rises the edge after the strobe, drops two edges later.
    always @(posedge clk) begin
        if (stub_mode == STUB_NOACK) begin
            stub_stall <= 1'b0;
        end else if (mif.memread || mif.memwrite) begin
            stub_stall <= 1'b1;
            busy       <= 2'd2;
            if (mif.memwrite && mif.addr == 32'h2000) led <= mif.write_data[7:0];
        end else if (stub_mode == STUB_HANG) begin
            if (hang_release) stub_stall <= 1'b0;
        end else if (busy != 2'd0) begin
            busy <= busy - 2'd1;
            if (busy == 2'd1) stub_stall <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rd_pulses = 0, wr_pulses = 0, acc_cnt = 0, resp_cnt = 0;
    int          acc_cyc = 0, resp_cyc = 0;
    logic [3:0]  cap_mask = 4'h0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0, cap_rdata = 32'h0;
    logic        cap_err = 1'b0;

    always @(negedge clk) begin
        if (mif.memread)  rd_pulses <= rd_pulses + 1;
        if (mif.memwrite) wr_pulses <= wr_pulses + 1;
        if (mif.memread || mif.memwrite) begin
            cap_mask  <= mif.sign_mask;
            cap_addr  <= mif.addr;
            cap_wdata <= mif.write_data;
        end
        if (rif.resp_valid) begin
            resp_cnt  <= resp_cnt + 1;
            resp_cyc  <= cyc;
            cap_err   <= rif.resp_err;
            cap_rdata <= rif.resp_rdata;
        end
        if (rif.valid && rif.ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; lat = edges from acceptance (inclusive) to resp_valid.
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic done, output int lat, output int rd, output int wr);
        int a0, r0, rd0, wr0, n;
        a0 = acc_cnt; r0 = resp_cnt; rd0 = rd_pulses; wr0 = wr_pulses;
        done = 1'b0; lat = -1;
        rif.we = we; rif.funct3 = f3; rif.addr = addr; rif.wdata = wdata;
        rif.valid = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin step(); n++; end
        rif.valid = 1'b0;
        if (acc_cnt != a0) begin
            n = 0;
            while (resp_cnt == r0 && n < 60) begin step(); n++; end
            done = (resp_cnt == r0 + 1);
            step();
            lat = resp_cyc - acc_cyc;
        end
        rd = rd_pulses - rd0;
        wr = wr_pulses - wr0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        err;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic        done;
        int          lat, rd, wr, first_acc, a0, r0, n;

        //          we    f3      addr          wdata         mdata         err   mask     rdata         lat rd wr
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b0111, 32'hDEAD_BEEF, 5, 1, 0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'hFFFF_FF80, 1'b0, 4'b1001, 32'hFFFF_FF80, 5, 1, 0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h0000_0080, 1'b0, 4'b0001, 32'h0000_0080, 5, 1, 0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'hFFFF_8000, 1'b0, 4'b1011, 32'hFFFF_8000, 5, 1, 0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_1002, 32'h0,        32'h0000_8000, 1'b0, 4'b0011, 32'h0000_8000, 5, 1, 0};
        vecs[5]  = '{1'b1, 3'b010, 32'h0000_2000, 32'h0000_00A5, 32'h1111_1111, 1'b0, 4'b0111, 32'h0,         5, 0, 1};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_1005, 32'h0000_0012, 32'h2222_2222, 1'b0, 4'b0001, 32'h0,         5, 0, 1};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_1006, 32'h0000_BEEF, 32'h3333_3333, 1'b0, 4'b0011, 32'h0,         5, 0, 1};
        vecs[8]  = '{1'b0, 3'b010, 32'h0000_1FFC, 32'h0,        32'hCAFE_F00D, 1'b0, 4'b0111, 32'hCAFE_F00D, 5, 1, 0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'h1234_5678, 1'b0, 4'b0111, 32'h1234_5678, 5, 1, 0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_1001, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[11] = '{1'b0, 3'b010, 32'h0000_0FFC, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[12] = '{1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[13] = '{1'b0, 3'b110, 32'h0000_1000, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[14] = '{1'b0, 3'b010, 32'h0000_2000, 32'h0,        32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[15] = '{1'b1, 3'b011, 32'h0000_1000, 32'h0000_0001, 32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[16] = '{1'b1, 3'b010, 32'h0000_1002, 32'h0000_0002, 32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};
        vecs[17] = '{1'b1, 3'b010, 32'h0000_2004, 32'h0000_0003, 32'h5555_5555, 1'b1, 4'b0000, 32'h0,         1, 0, 0};

        rif.valid = 1'b0; rif.we = 1'b0; rif.funct3 = 3'b000;
        rif.addr = 32'h0; rif.wdata = 32'h0;

        // ---- reset state ----
        reset = 1'b1;
        repeat (3) step();
        check("ready in reset", 32'(rif.ready), 32'h0);
        reset = 1'b0;
        step();
        check("reset resp_valid", 32'(rif.resp_valid), 32'h0);
        check("reset resp_rdata", rif.resp_rdata, 32'h0);
        check("reset memread", 32'(mif.memread), 32'h0);
        check("reset memwrite", 32'(mif.memwrite), 32'h0);
        check("reset mem_addr", mif.addr, 32'h0);
        check("reset sign_mask", 32'(mif.sign_mask), 32'h0);
        check("ready after reset", 32'(rif.ready), 32'h1);

        // ---- table-driven vectors ----
        for (int i = 0; i < 18; i++) begin
            stub_rdata = vecs[i].mdata;
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, done, lat, rd, wr);
            check($sformatf("v%0d done", i), 32'(done), 32'h1);
            check($sformatf("v%0d err", i), 32'(cap_err), 32'(vecs[i].err));
            check($sformatf("v%0d rdata", i), cap_rdata, vecs[i].rdata);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d memread pulses", i), 32'(rd), 32'(vecs[i].rd));
            check($sformatf("v%0d memwrite pulses", i), 32'(wr), 32'(vecs[i].wr));
            if (!vecs[i].err) begin
                check($sformatf("v%0d sign_mask", i), 32'(cap_mask), 32'(vecs[i].mask));
                check($sformatf("v%0d mem_addr", i), cap_addr, vecs[i].addr);
                if (vecs[i].we)
                    check($sformatf("v%0d write_data", i), cap_wdata, vecs[i].wdata);
            end
        end
        check("led after SW", 32'(led), 32'h0000_00A5);

        // ---- back-to-back throughput ----
        stub_rdata = 32'hA5A5_0001;
        a0 = acc_cnt; r0 = resp_cnt;
        rif.we = 1'b0; rif.funct3 = F3_LW; rif.addr = 32'h0000_1010; rif.valid = 1'b1;
        n = 0;
        while (acc_cnt < a0 + 1 && n < 50) begin step(); n++; end
        first_acc = acc_cyc;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 50) begin step(); n++; end
        rif.valid = 1'b0;
        check("b2b accepts", 32'(acc_cnt - a0), 32'h2);
        check("b2b spacing", 32'(acc_cyc - first_acc), 32'h6);
        n = 0;
        while (resp_cnt < r0 + 2 && n < 50) begin step(); n++; end
        check("b2b responses", 32'(resp_cnt - r0), 32'h2);
        step();

        // ---- stall never falls: timeout ----
        stub_mode = STUB_HANG; hang_release = 1'b0;
        run_txn(1'b0, F3_LW, 32'h0000_1000, 32'h0, done, lat, rd, wr);
        check("timeout done", 32'(done), 32'h1);
        check("timeout err", 32'(cap_err), 32'h1);
        check("timeout rdata", cap_rdata, 32'h0);
        check("timeout latency", 32'(lat), 32'd19);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("timeout ready blocked %0d", k), 32'(rif.ready), 32'h0);
            step();
        end
        hang_release = 1'b1;
        step();
        check("timeout ready after release", 32'(rif.ready), 32'h1);
        hang_release = 1'b0;
        stub_mode = STUB_NORMAL;

        // ---- stall never rises ----
        stub_mode = STUB_NOACK;
        run_txn(1'b0, F3_LW, 32'h0000_1000, 32'h0, done, lat, rd, wr);
        check("noack err", 32'(cap_err), 32'h1);
        check("noack latency", 32'(lat), 32'd3);
        check("noack memread pulses", 32'(rd), 32'h1);
        stub_mode = STUB_NORMAL;
        step();

        // ---- reset during WAIT_LO ----
        stub_mode = STUB_HANG; hang_release = 1'b0;
        a0 = acc_cnt;
        rif.we = 1'b0; rif.funct3 = F3_LW; rif.addr = 32'h0000_1000; rif.valid = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin step(); n++; end
        rif.valid = 1'b0;
        check("mid reset accepted", 32'(acc_cnt - a0), 32'h1);
        repeat (3) step();
        r0 = resp_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset memread", 32'(mif.memread), 32'h0);
        check("mid reset memwrite", 32'(mif.memwrite), 32'h0);
        check("mid reset mem_addr", mif.addr, 32'h0);
        check("mid reset ready held", 32'(rif.ready), 32'h0);
        repeat (20) step();
        check("mid reset no resp", 32'(resp_cnt - r0), 32'h0);
        check("mid reset ready still held", 32'(rif.ready), 32'h0);
        hang_release = 1'b1;
        step();
        check("mid reset ready after release", 32'(rif.ready), 32'h1);
        hang_release = 1'b0;
        stub_mode = STUB_NORMAL;

        stub_rdata = 32'h0BAD_F00D;
        run_txn(1'b0, F3_LW, 32'h0000_1008, 32'h0, done, lat, rd, wr);
        check("post reset done", 32'(done), 32'h1);
        check("post reset err", 32'(cap_err), 32'h0);
        check("post reset rdata", cap_rdata, 32'h0BAD_F00D);
        check("post reset latency", 32'(lat), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
